frame_buf_arbiter: RTL and testbench
====================================

# frame_buf_arbiter

Parametrised N-buffer frame-store controller sitting between the camera write FIFO, the display read FIFO and the SDRAM burst controller, all in the `clk_100m` domain. It arbitrates SDRAM write and read bursts with round-robin fairness. It rotates 3–4 frame buffers so the display never reads a frame being written. It aborts and counts frames truncated by an early vsync, and raises `vga_init_value` once the first complete frame is available.

## Interface
- `DATA_W`, 16: pixel word width; informational only, no data passes through this block.
- `ADDR_W`, 24: SDRAM word-address width.
- `H_ACT`, 640: active pixels per line.
- `V_ACT`, 480: active lines per frame.
- `BURST_LEN`, 256: words per SDRAM burst. `H_ACT*V_ACT` must be a multiple of it.
- `NUM_BUF`, 3: number of frame buffers, legal range 3..4.
- `BUF_STRIDE`, 2**19: word spacing between buffer bases. Power of two, ≥ `H_ACT*V_ACT`.
- `FIFO_CNT_W`, 10: width of the FIFO level inputs.

Ports:
- `clk`  in  1: system clock (`clk_100m` net).
- `rst_n`  in  1: reset, synchronous, active-low.
- `vsync_pos`  in  1: one-cycle camera frame-start pulse, already synchronised to `clk`.
- `rd_frame_start`  in  1: one-cycle display frame-start pulse.
- `wr_fifo_cnt`  in  FIFO_CNT_W: words available in the write FIFO.
- `rd_fifo_space`  in  FIFO_CNT_W: free words in the read FIFO.
- `wr_req`  out  1: write burst request.
- `wr_addr`  out  ADDR_W: burst start address.
- `wr_ack`  in  1: write burst accepted.
- `wr_done`  in  1: write burst finished.
- `rd_req`  out  1: read burst request.
- `rd_addr`  out  ADDR_W: burst start address.
- `rd_ack`  in  1: read burst accepted.
- `rd_done`  in  1: read burst finished.
- `wr_fifo_clr`  out  1: one-cycle pulse that flushes the write FIFO on frame abort.
- `vga_init_value`  out  1: sticky flag, first frame ready.
- `wr_buf_idx`  out  2: buffer currently being written.
- `rd_buf_idx`  out  2: buffer currently being read.
- `drop_cnt`  out  16: count of aborted frames, saturating.

## Operation
- FSM states: IDLE, WR_REQ, WR_BUSY, RD_REQ, RD_BUSY.
- IDLE:
  - Apply any latched frame events (see event handling).
  - Evaluate `wr_pend = wr_active & (wr_fifo_cnt ≥ BURST_LEN)` and `rd_pend = rd_active & (rd_fifo_space ≥ BURST_LEN)`.
  - Only `wr_pend` true → WR_REQ. Only `rd_pend` true → RD_REQ.
  - Both true → grant the side not granted last. `last_grant` resets to "read", so the first tie goes to write.
- WR_REQ:
  - Hold `wr_req=1`, `wr_addr = wr_buf_idx*BUF_STRIDE + wr_word`.
  - On `wr_ack` → WR_BUSY.
- WR_BUSY:
  - On `wr_done`: `wr_word += BURST_LEN` → IDLE.
- RD_REQ / RD_BUSY: same handshake using `rd_*` and `rd_word`.
- Frame-event handling:
  - `vsync_pos` and `rd_frame_start` are latched into pending flags whenever they arrive.
  - Pending flags are applied only in IDLE, so an in-flight burst always completes before an event takes effect.
- Write event, applied on the pending `vsync_pos` flag:
  - Frame complete (`wr_word == FRAME_WORDS`): `comp_idx <= wr_buf_idx`, `comp_valid <= 1`. Then `wr_buf_idx` becomes the lowest index not equal to `rd_buf_idx` and not equal to the new `comp_idx`.
  - Frame partial and `wr_active`: `drop_cnt++` (saturates at 0xFFFF) and `wr_fifo_clr` pulses. Same buffer is reused.
  - Either case: `wr_word <= 0`, `wr_active <= 1`.
  - `wr_active` drops when `wr_word` reaches `FRAME_WORDS`.
- Read event, applied on the pending `rd_frame_start` flag:
  - If `comp_valid`: `rd_buf_idx <= comp_idx`, `rd_word <= 0`, `rd_active <= 1`, `vga_init_value <= 1` (sticky).
  - Otherwise: no change, and `rd_active` stays 0.
  - A repeated read event with no new frame re-reads the same buffer.
  - `rd_active` drops when `rd_word == FRAME_WORDS`.
- Both events pending in the same IDLE cycle: the write event is applied first, so the reader takes the freshest frame.
- Arithmetic:
  - `FRAME_WORDS = H_ACT*V_ACT`.
  - Word counters are `clog2(FRAME_WORDS+1)` bits.
  - Addresses are computed at `ADDR_W`, no wrap.

## Timing
- Reset: FSM = IDLE; all req/pulse outputs = 0; `drop_cnt` = 0; `vga_init_value` = 0; `wr_buf_idx` = 0; `rd_buf_idx` = NUM_BUF-1; `wr_active` = `rd_active` = `comp_valid` = 0; `wr_word` = `rd_word` = 0; pending flags cleared.
- Reset mid-burst abandons the burst. The SDRAM controller is reset by the same `rst_n`.
- Latencies:
  - `req` rises 1 cycle after the IDLE decision cycle.
  - `ack` in the same cycle as `req` is legal.
  - `req` falls the cycle after `ack`.
  - Return to IDLE is 1 cycle after `done`.
- `wr_fifo_clr` lasts exactly one cycle, in the cycle after the event is applied.
- Outputs are registered; no combinational input-to-output paths.

## Structure
- Package `frame_buf_pkg`: FSM state enum, `FRAME_WORDS` localparam function, `next_wr_buf(rd_idx, comp_idx, num_buf)` function.
- Sub-module `fb_burst_arb`: the 5-state FSM with round-robin arbitration and req/ack/done handshakes.
- The top level holds buffer indices, frame counters and event latching.

## Test plan
- **Single frame.** `H_ACT=32`, `V_ACT=16`, `BURST_LEN=64`, `wr_fifo_cnt` held at 64, `vsync_pos` once. Expect 8 write bursts at addresses 0, 64, …, 448, then `wr_req` stays low.
- **First frame ready.** After the single frame, apply `vsync_pos` then `rd_frame_start`. Expect `comp_idx=0`, `wr_buf_idx=1`, `rd_buf_idx=0`, `vga_init_value=1`. Next read burst address = 0.
- **Contention.** Both sides pending continuously. Expect grants W, R, W, R strictly alternating.
- **Abort.** `vsync_pos` after 3 write bursts. Expect `drop_cnt=1`, one `wr_fifo_clr` pulse, next `wr_addr = wr_buf_idx*BUF_STRIDE + 0`, buffer unchanged.
- **Event during burst.** `vsync_pos` arrives while in WR_BUSY. Expect the burst to complete (`wr_word` advances) before the event is applied.
- **Simultaneous events.** `vsync_pos` and `rd_frame_start` in the same cycle with `wr_word=FRAME_WORDS`. Expect the reader to switch to the just-completed buffer, and the writer to pick the third index.

Source files
------------

// File: rtl/frame_buf_pkg.sv
// frame_buf_pkg: shared FSM state type and helpers for the frame-buffer arbiter.
package frame_buf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_BUSY,
    ST_RD_REQ,
    ST_RD_BUSY
  } arb_state_t;

  function automatic int frame_words(input int h_act, input int v_act);
    return h_act * v_act;
  endfunction

  // Lowest buffer index that is neither being displayed nor holding the newest complete frame.
  function automatic logic [1:0] next_wr_buf(input logic [1:0] rd_idx, input logic [1:0] comp_idx,
                                             input int num_buf);
    logic [1:0] idx;
    idx = '0;
    for (int i = 3; i >= 0; i--)
      if (i < num_buf && 2'(i) != rd_idx && 2'(i) != comp_idx) idx = 2'(i);
    return idx;
  endfunction

endpackage

// File: rtl/fb_burst_arb.sv
// fb_burst_arb: five-state SDRAM burst FSM with round-robin write/read arbitration.
module fb_burst_arb
  import frame_buf_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_hold,
  input  logic i_wr_pend,
  input  logic i_rd_pend,
  input  logic i_wr_ack,
  input  logic i_wr_done,
  input  logic i_rd_ack,
  input  logic i_rd_done,
  output logic o_wr_req,
  output logic o_rd_req,
  output logic o_idle,
  output logic o_wr_fin,
  output logic o_rd_fin
);

  arb_state_t r_state, w_state_nx;
  logic       r_last_rd, w_last_rd_nx;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_last_rd <= 1'b1;
    end else begin
      r_state   <= w_state_nx;
      r_last_rd <= w_last_rd_nx;
    end
  end

  // A pending frame event freezes new grants so it is applied against stable counters.
  always_comb begin
    w_state_nx   = r_state;
    w_last_rd_nx = r_last_rd;
    case (r_state)
      ST_IDLE:
        if (!i_hold) begin
          if (i_wr_pend && (!i_rd_pend || r_last_rd)) begin
            w_state_nx   = ST_WR_REQ;
            w_last_rd_nx = 1'b0;
          end else if (i_rd_pend) begin
            w_state_nx   = ST_RD_REQ;
            w_last_rd_nx = 1'b1;
          end
        end
      ST_WR_REQ:  w_state_nx = i_wr_ack ? ST_WR_BUSY : ST_WR_REQ;
      ST_WR_BUSY: w_state_nx = i_wr_done ? ST_IDLE : ST_WR_BUSY;
      ST_RD_REQ:  w_state_nx = i_rd_ack ? ST_RD_BUSY : ST_RD_REQ;
      ST_RD_BUSY: w_state_nx = i_rd_done ? ST_IDLE : ST_RD_BUSY;
      default:    w_state_nx = ST_IDLE;
    endcase
  end

  assign o_wr_req = r_state == ST_WR_REQ;
  assign o_rd_req = r_state == ST_RD_REQ;
  assign o_idle   = r_state == ST_IDLE;
  assign o_wr_fin = r_state == ST_WR_BUSY && i_wr_done;
  assign o_rd_fin = r_state == ST_RD_BUSY && i_rd_done;

endmodule

// File: rtl/frame_buf_arbiter.sv
// frame_buf_arbiter: rotates 3-4 SDRAM frame buffers between camera writer and display reader,
// latching frame events, counting aborted frames and flagging the first complete frame.
module frame_buf_arbiter
  import frame_buf_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 24,
  parameter int H_ACT      = 640,
  parameter int V_ACT      = 480,
  parameter int BURST_LEN  = 256,
  parameter int NUM_BUF    = 3,
  parameter int BUF_STRIDE = 2 ** 19,
  parameter int FIFO_CNT_W = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  vsync_pos,
  input  logic                  rd_frame_start,
  input  logic [FIFO_CNT_W-1:0] wr_fifo_cnt,
  input  logic [FIFO_CNT_W-1:0] rd_fifo_space,
  output logic                  wr_req,
  output logic [ADDR_W-1:0]     wr_addr,
  input  logic                  wr_ack,
  input  logic                  wr_done,
  output logic                  rd_req,
  output logic [ADDR_W-1:0]     rd_addr,
  input  logic                  rd_ack,
  input  logic                  rd_done,
  output logic                  wr_fifo_clr,
  output logic                  vga_init_value,
  output logic [1:0]            wr_buf_idx,
  output logic [1:0]            rd_buf_idx,
  output logic [15:0]           drop_cnt
);

  localparam int FW = frame_words(H_ACT, V_ACT);
  localparam int WC_W = $clog2(FW + 1);
  localparam logic [WC_W-1:0] FW_C = WC_W'(FW);
  localparam logic [WC_W-1:0] BL_C = WC_W'(BURST_LEN);
  localparam logic [ADDR_W-1:0] STRIDE_A = ADDR_W'(BUF_STRIDE);

  if (DATA_W < 1 || NUM_BUF < 3 || NUM_BUF > 4 || FW % BURST_LEN != 0 || BUF_STRIDE < FW)
  begin : g_bad_param
    $error("frame_buf_arbiter: illegal parameter set");
  end

  logic            r_vs_pend, r_rf_pend;
  logic            r_wr_active, r_rd_active, r_comp_valid;
  logic [1:0]      r_comp_idx, r_wr_buf_idx, r_rd_buf_idx;
  logic [WC_W-1:0] r_wr_word, r_rd_word;
  logic [15:0]     r_drop_cnt;
  logic            r_wr_fifo_clr, r_vga_init;
  logic [ADDR_W-1:0] r_wr_addr, r_rd_addr;

  logic            w_idle, w_wr_fin, w_rd_fin, w_wr_req, w_rd_req;
  logic            w_apply_w, w_apply_r, w_wr_complete, w_comp_valid_n;
  logic [1:0]      w_comp_idx_n;
  logic [WC_W-1:0] w_wr_word_nx, w_rd_word_nx;
  logic            w_wr_pend, w_rd_pend;

  assign w_wr_pend      = r_wr_active && 32'(wr_fifo_cnt) >= BURST_LEN;
  assign w_rd_pend      = r_rd_active && 32'(rd_fifo_space) >= BURST_LEN;
  assign w_apply_w      = w_idle && r_vs_pend;
  assign w_apply_r      = w_idle && r_rf_pend;
  assign w_wr_complete  = r_wr_word == FW_C;
  // Write event resolves first so a simultaneous read event picks up the frame just closed.
  assign w_comp_idx_n   = (w_apply_w && w_wr_complete) ? r_wr_buf_idx : r_comp_idx;
  assign w_comp_valid_n = r_comp_valid || (w_apply_w && w_wr_complete);
  assign w_wr_word_nx   = r_wr_word + BL_C;
  assign w_rd_word_nx   = r_rd_word + BL_C;

  fb_burst_arb u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_hold   (r_vs_pend || r_rf_pend),
    .i_wr_pend(w_wr_pend),
    .i_rd_pend(w_rd_pend),
    .i_wr_ack (wr_ack),
    .i_wr_done(wr_done),
    .i_rd_ack (rd_ack),
    .i_rd_done(rd_done),
    .o_wr_req (w_wr_req),
    .o_rd_req (w_rd_req),
    .o_idle   (w_idle),
    .o_wr_fin (w_wr_fin),
    .o_rd_fin (w_rd_fin)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vs_pend     <= 1'b0;
      r_rf_pend     <= 1'b0;
      r_wr_active   <= 1'b0;
      r_rd_active   <= 1'b0;
      r_comp_valid  <= 1'b0;
      r_comp_idx    <= '0;
      r_wr_buf_idx  <= '0;
      r_rd_buf_idx  <= 2'(NUM_BUF - 1);
      r_wr_word     <= '0;
      r_rd_word     <= '0;
      r_drop_cnt    <= '0;
      r_wr_fifo_clr <= 1'b0;
      r_vga_init    <= 1'b0;
      r_wr_addr     <= '0;
      r_rd_addr     <= '0;
    end else begin
      r_vs_pend     <= vsync_pos || (r_vs_pend && !w_apply_w);
      r_rf_pend     <= rd_frame_start || (r_rf_pend && !w_apply_r);
      r_wr_fifo_clr <= w_apply_w && !w_wr_complete && r_wr_active;
      r_comp_idx    <= w_comp_idx_n;
      r_comp_valid  <= w_comp_valid_n;
      if (w_apply_w) begin
        r_wr_word   <= '0;
        r_wr_active <= 1'b1;
        if (w_wr_complete) r_wr_buf_idx <= next_wr_buf(r_rd_buf_idx, r_wr_buf_idx, NUM_BUF);
        else if (r_wr_active && r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
      end else if (w_wr_fin) begin
        r_wr_word <= w_wr_word_nx;
        if (w_wr_word_nx == FW_C) r_wr_active <= 1'b0;
      end
      if (w_apply_r && w_comp_valid_n) begin
        r_rd_buf_idx <= w_comp_idx_n;
        r_rd_word    <= '0;
        r_rd_active  <= 1'b1;
        r_vga_init   <= 1'b1;
      end else if (w_rd_fin) begin
        r_rd_word <= w_rd_word_nx;
        if (w_rd_word_nx == FW_C) r_rd_active <= 1'b0;
      end
      r_wr_addr <= ADDR_W'(r_wr_buf_idx) * STRIDE_A + ADDR_W'(r_wr_word);
      r_rd_addr <= ADDR_W'(r_rd_buf_idx) * STRIDE_A + ADDR_W'(r_rd_word);
    end
  end

  assign wr_req         = w_wr_req;
  assign rd_req         = w_rd_req;
  assign wr_addr        = r_wr_addr;
  assign rd_addr        = r_rd_addr;
  assign wr_fifo_clr    = r_wr_fifo_clr;
  assign vga_init_value = r_vga_init;
  assign wr_buf_idx     = r_wr_buf_idx;
  assign rd_buf_idx     = r_rd_buf_idx;
  assign drop_cnt       = r_drop_cnt;

endmodule

// File: tb/tb_frame_buf_arbiter.sv
// tb_frame_buf_arbiter: directed scenarios for frame_buf_arbiter with a small 32x16 frame.
module tb_frame_buf_arbiter;

  localparam int STR = 2 ** 19;

  logic        clk = 0;
  logic        rst_n = 0;
  logic        vsync_pos = 0, rd_frame_start = 0;
  logic [9:0]  wr_fifo_cnt = 0, rd_fifo_space = 0;
  logic        wr_req, rd_req, wr_fifo_clr, vga_init_value;
  logic [23:0] wr_addr, rd_addr;
  logic        wr_ack = 0, wr_done = 0, rd_ack = 0, rd_done = 0;
  logic [1:0]  wr_buf_idx, rd_buf_idx;
  logic [15:0] drop_cnt;

  int errors = 0;
  int checks = 0;
  int clr_cnt = 0;

  frame_buf_arbiter #(
    .DATA_W(16), .ADDR_W(24), .H_ACT(32), .V_ACT(16), .BURST_LEN(64),
    .NUM_BUF(3), .BUF_STRIDE(STR), .FIFO_CNT_W(10)
  ) dut (
    .clk(clk), .rst_n(rst_n), .vsync_pos(vsync_pos), .rd_frame_start(rd_frame_start),
    .wr_fifo_cnt(wr_fifo_cnt), .rd_fifo_space(rd_fifo_space),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_ack(wr_ack), .wr_done(wr_done),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_done(rd_done),
    .wr_fifo_clr(wr_fifo_clr), .vga_init_value(vga_init_value),
    .wr_buf_idx(wr_buf_idx), .rd_buf_idx(rd_buf_idx), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (wr_fifo_clr === 1'b1) clr_cnt++;

  task automatic serve(output bit ok, output bit is_rd, output logic [23:0] a);
    ok = 0; is_rd = 0; a = '0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (wr_req || rd_req) begin
        ok = 1; is_rd = rd_req; a = rd_req ? rd_addr : wr_addr;
      end
    end
    if (!ok) return;
    if (is_rd) rd_ack = 1; else wr_ack = 1;
    @(negedge clk); rd_ack = 0; wr_ack = 0;
    @(negedge clk); @(negedge clk);
    if (is_rd) rd_done = 1; else wr_done = 1;
    @(negedge clk); rd_done = 0; wr_done = 0;
  endtask

  task automatic pulse(input bit vs, input bit rf);
    @(negedge clk); vsync_pos = vs; rd_frame_start = rf;
    @(negedge clk); vsync_pos = 0; rd_frame_start = 0;
  endtask

  task automatic test_reset;
    rst_n = 0;
    repeat (3) @(negedge clk);
    checks++; if (wr_req !== 0 || rd_req !== 0) begin errors++; $display("FAIL reset_req got wr=%b rd=%b want 0 0", wr_req, rd_req); end
    checks++; if (wr_buf_idx !== 0 || rd_buf_idx !== 2) begin errors++; $display("FAIL reset_idx got wr=%0d rd=%0d want 0 2", wr_buf_idx, rd_buf_idx); end
    checks++; if (drop_cnt !== 0 || vga_init_value !== 0 || wr_fifo_clr !== 0) begin errors++; $display("FAIL reset_flags got drop=%0d vga=%b clr=%b want 0 0 0", drop_cnt, vga_init_value, wr_fifo_clr); end
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_single_frame;
    bit ok, r; logic [23:0] a; int low;
    wr_fifo_cnt = 64;
    pulse(1, 0);
    for (int i = 0; i < 8; i++) begin
      serve(ok, r, a);
      checks++; if (!ok || r || a !== 24'(i * 64)) begin errors++; $display("FAIL single_burst%0d got ok=%b rd=%b addr=%0d want write addr %0d", i, ok, r, a, i * 64); end
    end
    low = 1;
    repeat (20) begin @(negedge clk); if (wr_req !== 0) low = 0; end
    checks++; if (low != 1) begin errors++; $display("FAIL single_idle got wr_req high want low after frame"); end
    checks++; if (drop_cnt !== 0 || clr_cnt != 0) begin errors++; $display("FAIL single_nodrop got drop=%0d clr=%0d want 0 0", drop_cnt, clr_cnt); end
  endtask

  task automatic test_first_frame;
    bit ok, r; logic [23:0] a;
    wr_fifo_cnt = 0;
    pulse(1, 0);
    repeat (3) @(negedge clk);
    checks++; if (wr_buf_idx !== 1 || clr_cnt != 0) begin errors++; $display("FAIL first_wr_idx got idx=%0d clr=%0d want 1 0", wr_buf_idx, clr_cnt); end
    checks++; if (vga_init_value !== 0) begin errors++; $display("FAIL first_vga_early got %b want 0", vga_init_value); end
    pulse(0, 1);
    repeat (2) @(negedge clk);
    checks++; if (rd_buf_idx !== 0 || vga_init_value !== 1) begin errors++; $display("FAIL first_rd got idx=%0d vga=%b want 0 1", rd_buf_idx, vga_init_value); end
    rd_fifo_space = 64;
    serve(ok, r, a);
    checks++; if (!ok || !r || a !== 24'd0) begin errors++; $display("FAIL first_rd_addr got ok=%b rd=%b addr=%0d want read addr 0", ok, r, a); end
  endtask

  task automatic test_contention;
    bit ok, r; logic [23:0] a;
    logic [23:0] exp_a [4];
    bit exp_r [4];
    exp_a = '{24'(STR), 24'd64, 24'(STR + 64), 24'd128};
    exp_r = '{0, 1, 0, 1};
    wr_fifo_cnt = 64; rd_fifo_space = 64;
    for (int i = 0; i < 4; i++) begin
      serve(ok, r, a);
      checks++; if (!ok || r !== exp_r[i] || a !== exp_a[i]) begin errors++; $display("FAIL contend%0d got ok=%b rd=%b addr=%0d want rd=%b addr=%0d", i, ok, r, a, exp_r[i], exp_a[i]); end
    end
    wr_fifo_cnt = 0; rd_fifo_space = 0;
  endtask

  task automatic test_abort;
    bit ok, r; logic [23:0] a; int c0;
    wr_fifo_cnt = 64;
    serve(ok, r, a);
    wr_fifo_cnt = 0;
    checks++; if (!ok || r || a !== 24'(STR + 128)) begin errors++; $display("FAIL abort_third got ok=%b rd=%b addr=%0d want write %0d", ok, r, a, STR + 128); end
    c0 = clr_cnt;
    pulse(1, 0);
    @(negedge clk);
    checks++; if (wr_fifo_clr !== 1 || drop_cnt !== 1) begin errors++; $display("FAIL abort_pulse got clr=%b drop=%0d want 1 1", wr_fifo_clr, drop_cnt); end
    @(negedge clk);
    checks++; if (wr_fifo_clr !== 0 || clr_cnt != c0 + 1 || wr_buf_idx !== 1) begin errors++; $display("FAIL abort_once got clr=%b cycles=%0d idx=%0d want 0 1 1", wr_fifo_clr, clr_cnt - c0, wr_buf_idx); end
    wr_fifo_cnt = 64;
    serve(ok, r, a);
    checks++; if (!ok || r || a !== 24'(STR)) begin errors++; $display("FAIL abort_restart got ok=%b rd=%b addr=%0d want write %0d", ok, r, a, STR); end
  endtask

  task automatic test_event_during_burst;
    bit ok, r; logic [23:0] a; int c0; bit seen;
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin @(negedge clk); seen = wr_req; end
    checks++; if (!seen || wr_addr !== 24'(STR + 64)) begin errors++; $display("FAIL busy_req got seen=%b addr=%0d want 1 %0d", seen, wr_addr, STR + 64); end
    wr_ack = 1; @(negedge clk); wr_ack = 0;
    c0 = clr_cnt;
    pulse(1, 0);
    repeat (2) @(negedge clk);
    checks++; if (drop_cnt !== 1 || clr_cnt != c0) begin errors++; $display("FAIL busy_held got drop=%0d clr=%0d want 1 0", drop_cnt, clr_cnt - c0); end
    wr_done = 1; @(negedge clk); wr_done = 0;
    repeat (3) @(negedge clk);
    checks++; if (drop_cnt !== 2 || clr_cnt != c0 + 1) begin errors++; $display("FAIL busy_applied got drop=%0d clr=%0d want 2 1", drop_cnt, clr_cnt - c0); end
    serve(ok, r, a);
    checks++; if (!ok || r || a !== 24'(STR)) begin errors++; $display("FAIL busy_restart got ok=%b rd=%b addr=%0d want write %0d", ok, r, a, STR); end
  endtask

  task automatic test_simultaneous;
    bit ok, r; logic [23:0] a; int c0;
    for (int i = 1; i < 8; i++) begin
      serve(ok, r, a);
      checks++; if (!ok || r || a !== 24'(STR + i * 64)) begin errors++; $display("FAIL sim_fill%0d got ok=%b rd=%b addr=%0d want %0d", i, ok, r, a, STR + i * 64); end
    end
    wr_fifo_cnt = 0;
    c0 = clr_cnt;
    pulse(1, 1);
    repeat (3) @(negedge clk);
    checks++; if (rd_buf_idx !== 1 || wr_buf_idx !== 2) begin errors++; $display("FAIL sim_idx got rd=%0d wr=%0d want 1 2", rd_buf_idx, wr_buf_idx); end
    checks++; if (drop_cnt !== 2 || clr_cnt != c0) begin errors++; $display("FAIL sim_nodrop got drop=%0d clr=%0d want 2 0", drop_cnt, clr_cnt - c0); end
    rd_fifo_space = 64;
    serve(ok, r, a);
    rd_fifo_space = 0;
    checks++; if (!ok || !r || a !== 24'(STR)) begin errors++; $display("FAIL sim_rd got ok=%b rd=%b addr=%0d want read %0d", ok, r, a, STR); end
    wr_fifo_cnt = 64;
    serve(ok, r, a);
    wr_fifo_cnt = 0;
    checks++; if (!ok || r || a !== 24'(2 * STR)) begin errors++; $display("FAIL sim_wr got ok=%b rd=%b addr=%0d want write %0d", ok, r, a, 2 * STR); end
  endtask

  task automatic test_reread;
    bit ok, r; logic [23:0] a;
    pulse(0, 1);
    repeat (2) @(negedge clk);
    rd_fifo_space = 64;
    serve(ok, r, a);
    rd_fifo_space = 0;
    checks++; if (rd_buf_idx !== 1 || !ok || !r || a !== 24'(STR)) begin errors++; $display("FAIL reread got idx=%0d ok=%b rd=%b addr=%0d want 1 read %0d", rd_buf_idx, ok, r, a, STR); end
  endtask

  initial begin
    test_reset;
    test_single_frame;
    test_first_frame;
    test_contention;
    test_abort;
    test_event_during_burst;
    test_simultaneous;
    test_reread;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
